// File: rtl/tunable_clock_gen_pkg.sv
// Shared types for tunable_clock_gen.
//   state_e    : output-clock FSM states
//   CMD_*      : inc_dec command encodings
//   clamp_op_e : operation selector for the period_clamp datapath
package tunable_clock_gen_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HIGH = 2'd1,
        LOW  = 2'd2
    } state_e;

    localparam logic [1:0] CMD_HOLD = 2'b00;
    localparam logic [1:0] CMD_INC  = 2'b01;
    localparam logic [1:0] CMD_DEC  = 2'b10;

    typedef enum logic [1:0] {
        OP_HOLD = 2'd0,
        OP_LOAD = 2'd1,
        OP_INC  = 2'd2,
        OP_DEC  = 2'd3
    } clamp_op_e;

endpackage

// File: rtl/tunable_clock_gen_if.sv
// Command / status bus of tunable_clock_gen.
//   load, load_val      : replace pending period
//   cmd_valid, inc_dec  : one-cycle lengthen/shorten command, amount = step
//   min_p, max_p        : runtime period limits
//   period_next         : pending period (status)
//   at_min, at_max      : pending period sits on the effective limit (status)
// master = command source, slave = generator.
interface tunable_clock_gen_if #(
    parameter int W = 8
);
    logic         load;
    logic [W-1:0] load_val;
    logic         cmd_valid;
    logic [1:0]   inc_dec;
    logic [W-1:0] step;
    logic [W-1:0] min_p;
    logic [W-1:0] max_p;
    logic [W-1:0] period_next;
    logic         at_min;
    logic         at_max;

    modport master (
        output load, load_val, cmd_valid, inc_dec, step, min_p, max_p,
        input  period_next, at_min, at_max
    );

    modport slave (
        input  load, load_val, cmd_valid, inc_dec, step, min_p, max_p,
        output period_next, at_min, at_max
    );
endinterface

// File: rtl/tunable_clock_gen_period_clamp.sv
// period_clamp: combinational candidate computation plus limit clamp.
//   op_i       : HOLD / LOAD / INC / DEC
//   base_i     : current pending period
//   step_i     : adjustment amount
//   load_val_i : value for LOAD
//   min_p_i    : runtime lower limit (raised to MIN_LEGAL)
//   max_p_i    : runtime upper limit
//   result_o   : clamped candidate
//   min_eff_o, max_eff_o : effective limits
// Arithmetic is done two bits wider and signed, so an add cannot wrap and
// a subtract below zero stays negative before clamping.
module period_clamp
    import tunable_clock_gen_pkg::*;
#(
    parameter int W         = 8,
    parameter int MIN_LEGAL = 2
) (
    input  clamp_op_e    op_i,
    input  logic [W-1:0] base_i,
    input  logic [W-1:0] step_i,
    input  logic [W-1:0] load_val_i,
    input  logic [W-1:0] min_p_i,
    input  logic [W-1:0] max_p_i,
    output logic [W-1:0] result_o,
    output logic [W-1:0] min_eff_o,
    output logic [W-1:0] max_eff_o
);
    localparam logic [W-1:0] MIN_L = W'(MIN_LEGAL);

    logic signed [W+1:0] cand;
    logic signed [W+1:0] lim_lo;
    logic signed [W+1:0] lim_hi;

    always_comb begin
        min_eff_o = (min_p_i > MIN_L) ? min_p_i : MIN_L;
        max_eff_o = max_p_i;
        lim_lo    = {2'b00, min_eff_o};
        lim_hi    = {2'b00, max_eff_o};
        case (op_i)
            OP_LOAD: cand = {2'b00, load_val_i};
            OP_INC:  cand = {2'b00, base_i} + {2'b00, step_i};
            OP_DEC:  cand = {2'b00, base_i} - {2'b00, step_i};
            default: cand = {2'b00, base_i};
        endcase
        // Upper clamp first, lower clamp last, so the minimum wins when the
        // limits cross.
        if (((cand > lim_hi) ? lim_hi : cand) < lim_lo)
            result_o = min_eff_o;
        else if (cand > lim_hi)
            result_o = max_eff_o;
        else
            result_o = cand[W-1:0];
    end
endmodule

// File: rtl/tunable_clock_gen.sv
// tunable_clock_gen: glitch-free programmable clock divider.
//   clk50, rst_r : clock, async active-high reset
//   en           : run (sampled only at period boundaries)
//   bus          : command/status interface (slave)
//   clk_out      : generated clock, registered
//   period       : period currently in use
//   tick         : one-cycle pulse with each clk_out rising edge
// Commands update the pending period at any time; the running period only
// takes the pending value on HIGH entry, so no phase is ever shortened.
module tunable_clock_gen
    import tunable_clock_gen_pkg::*;
#(
    parameter int W           = 8,
    parameter int INIT_PERIOD = 125,
    parameter int MIN_LEGAL   = 2
) (
    input  logic                clk50,
    input  logic                rst_r,
    input  logic                en,
    tunable_clock_gen_if.slave  bus,
    output logic                clk_out,
    output logic [W-1:0]        period,
    output logic                tick
);
    localparam logic [W-1:0] INIT_P =
        W'((INIT_PERIOD < MIN_LEGAL) ? MIN_LEGAL : INIT_PERIOD);

    state_e       state_q, state_d;
    logic [W-1:0] cnt_q, cnt_d;
    logic         clk_q, clk_d;
    logic         tick_q, tick_d;
    logic [W-1:0] period_q, period_d;
    logic [W-1:0] pn_q, pn_d;
    logic         start;

    clamp_op_e    op;
    logic [W-1:0] clamp_res, min_eff, max_eff;

    // load beats a command; zero step or a hold code leaves pending untouched
    always_comb begin
        op = OP_HOLD;
        if (bus.load)
            op = OP_LOAD;
        else if (bus.cmd_valid && (bus.step != '0)) begin
            case (bus.inc_dec)
                CMD_INC: op = OP_INC;
                CMD_DEC: op = OP_DEC;
                default: op = OP_HOLD;
            endcase
        end
    end

    period_clamp #(.W(W), .MIN_LEGAL(MIN_LEGAL)) u_clamp (
        .op_i       (op),
        .base_i     (pn_q),
        .step_i     (bus.step),
        .load_val_i (bus.load_val),
        .min_p_i    (bus.min_p),
        .max_p_i    (bus.max_p),
        .result_o   (clamp_res),
        .min_eff_o  (min_eff),
        .max_eff_o  (max_eff)
    );

    assign pn_d = (op == OP_HOLD) ? pn_q : clamp_res;

    // cnt_q holds remaining cycles of the current phase minus one
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        clk_d    = clk_q;
        tick_d   = 1'b0;
        period_d = period_q;
        start    = 1'b0;
        case (state_q)
            IDLE: begin
                clk_d = 1'b0;
                start = en;
            end
            HIGH: begin
                if (cnt_q == '0) begin
                    state_d = LOW;
                    clk_d   = 1'b0;
                    cnt_d   = (period_q >> 1) - W'(1);
                end else begin
                    cnt_d = cnt_q - W'(1);
                end
            end
            LOW: begin
                if (cnt_q == '0) begin
                    if (en) begin
                        start = 1'b1;
                    end else begin
                        state_d = IDLE;
                        clk_d   = 1'b0;
                    end
                end else begin
                    cnt_d = cnt_q - W'(1);
                end
            end
            default: begin
                state_d = IDLE;
                clk_d   = 1'b0;
            end
        endcase
        if (start) begin
            state_d  = HIGH;
            clk_d    = 1'b1;
            tick_d   = 1'b1;
            period_d = pn_q;
            cnt_d    = pn_q - (pn_q >> 1) - W'(1);
        end
    end

    always_ff @(posedge clk50 or posedge rst_r) begin
        if (rst_r) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            clk_q    <= 1'b0;
            tick_q   <= 1'b0;
            period_q <= INIT_P;
            pn_q     <= INIT_P;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            clk_q    <= clk_d;
            tick_q   <= tick_d;
            period_q <= period_d;
            pn_q     <= pn_d;
        end
    end

    assign clk_out         = clk_q;
    assign tick            = tick_q;
    assign period          = period_q;
    assign bus.period_next = pn_q;
    assign bus.at_min      = (pn_q == min_eff);
    assign bus.at_max      = (pn_q == max_eff);
endmodule

// File: tb/tb_tunable_clock_gen.sv
module tb_tunable_clock_gen;
    localparam int W = 8;

    logic         clk50 = 1'b0;
    logic         rst_r;
    logic         en;
    logic         clk_out;
    logic [W-1:0] period;
    logic         tick;

    tunable_clock_gen_if #(.W(W)) bus ();

    tunable_clock_gen #(.W(W), .INIT_PERIOD(125), .MIN_LEGAL(2)) dut (
        .clk50   (clk50),
        .rst_r   (rst_r),
        .en      (en),
        .bus     (bus),
        .clk_out (clk_out),
        .period  (period),
        .tick    (tick)
    );

    always #5 clk50 = ~clk50;

    int total = 0;
    int bad   = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    // Reference model: pending value by plain integer arithmetic, output
    // clock as a queue of future levels filled once per period.
    int mpn, mper;
    bit mq[$];
    bit eclk, etick;

    function automatic int mmin(input int mn);
        return (mn > 2) ? mn : 2;
    endfunction

    function automatic int mclamp(input int v, input int mn, input int mx);
        int r;
        r = (v > mx) ? mx : v;
        if (r < mmin(mn)) r = mmin(mn);
        return r;
    endfunction

    task automatic model_reset();
        mpn = 125; mper = 125; mq.delete(); eclk = 0; etick = 0;
    endtask

    task automatic model_edge();
        int mn, mx;
        mn = int'(bus.min_p); mx = int'(bus.max_p);
        etick = 0;
        if (mq.size() == 0 && en) begin
            mper = mpn;
            for (int i = 0; i < mper - mper / 2; i++) mq.push_back(1'b1);
            for (int i = 0; i < mper / 2; i++) mq.push_back(1'b0);
            etick = 1;
        end
        eclk = (mq.size() != 0) ? mq.pop_front() : 1'b0;
        if (bus.load)
            mpn = mclamp(int'(bus.load_val), mn, mx);
        else if (bus.cmd_valid && bus.step != 0 && bus.inc_dec == 2'b01)
            mpn = mclamp(mpn + int'(bus.step), mn, mx);
        else if (bus.cmd_valid && bus.step != 0 && bus.inc_dec == 2'b10)
            mpn = mclamp(mpn - int'(bus.step), mn, mx);
    endtask

    task automatic cyc();
        @(posedge clk50);
        model_edge();
        @(negedge clk50);
        chk("clk_out", 32'(clk_out), 32'(eclk));
        chk("tick", 32'(tick), 32'(etick));
        chk("period", 32'(period), 32'(mper));
        chk("period_next", 32'(bus.period_next), 32'(mpn));
        chk("at_min", 32'(bus.at_min), 32'(mpn == mmin(int'(bus.min_p))));
        chk("at_max", 32'(bus.at_max), 32'(mpn == int'(bus.max_p)));
    endtask

    task automatic wait_tick();
        bit ok = 0;
        for (int n = 0; n < 600 && !ok; n++) begin
            cyc();
            if (tick) ok = 1;
        end
        if (!ok) chk("tick_timeout", 0, 1);
    endtask

    // Called on a tick cycle; counts high and low cycles up to the next rise.
    task automatic measure(output int hi, output int lo);
        hi = 1; lo = 0;
        for (int n = 0; n < 600; n++) begin
            cyc();
            if (clk_out && !tick) hi++;
            else break;
        end
        for (int n = 0; n < 600 && !clk_out; n++) begin
            lo++;
            cyc();
        end
    endtask

    typedef struct {
        int ld, lv, cv, id, st, mn, mx, epn, eamin, eamax;
    } vec_t;
    vec_t tv[13];

    initial begin
        int hi, lo, hc, tk;
        rst_r = 1; en = 0;
        bus.load = 0; bus.load_val = 0; bus.cmd_valid = 0; bus.inc_dec = 0;
        bus.step = 0; bus.min_p = 0; bus.max_p = 255;
        model_reset();
        @(negedge clk50);
        chk("rst_clk_out", 32'(clk_out), 0);
        chk("rst_tick", 32'(tick), 0);
        chk("rst_period", 32'(period), 125);
        chk("rst_period_next", 32'(bus.period_next), 125);
        @(negedge clk50);
        rst_r = 0;

        //        ld  lv   cv id st   mn   mx   epn amin amax
        tv[0]  = '{1, 155, 0, 0, 0,   90,  160, 155, 0, 0};
        tv[1]  = '{0, 0,   1, 1, 20,  90,  160, 160, 0, 1};
        tv[2]  = '{0, 0,   1, 1, 20,  90,  160, 160, 0, 1};
        tv[3]  = '{0, 0,   1, 2, 20,  90,  160, 140, 0, 0};
        tv[4]  = '{1, 5,   0, 0, 0,   0,   160, 5,   0, 0};
        tv[5]  = '{0, 0,   1, 2, 50,  0,   160, 2,   1, 0};
        tv[6]  = '{0, 0,   1, 2, 50,  0,   160, 2,   1, 0};
        tv[7]  = '{1, 90,  0, 0, 0,   100, 80,  100, 1, 0};
        tv[8]  = '{0, 0,   1, 1, 0,   0,   255, 100, 0, 0};
        tv[9]  = '{0, 0,   1, 3, 7,   0,   255, 100, 0, 0};
        tv[10] = '{1, 200, 1, 1, 5,   0,   255, 200, 0, 0};
        tv[11] = '{0, 0,   1, 1, 100, 0,   255, 255, 0, 1};
        tv[12] = '{1, 125, 0, 0, 0,   0,   255, 125, 0, 0};
        foreach (tv[i]) begin
            bus.load = 1'(tv[i].ld); bus.load_val = 8'(tv[i].lv);
            bus.cmd_valid = 1'(tv[i].cv); bus.inc_dec = 2'(tv[i].id);
            bus.step = 8'(tv[i].st); bus.min_p = 8'(tv[i].mn); bus.max_p = 8'(tv[i].mx);
            cyc();
            chk($sformatf("vec%0d_period_next", i), 32'(bus.period_next), 32'(tv[i].epn));
            chk($sformatf("vec%0d_at_min", i), 32'(bus.at_min), 32'(tv[i].eamin));
            chk($sformatf("vec%0d_at_max", i), 32'(bus.at_max), 32'(tv[i].eamax));
        end
        bus.load = 0; bus.cmd_valid = 0; bus.step = 0; bus.inc_dec = 0;
        bus.min_p = 0; bus.max_p = 255;

        // default period 125: high 63, low 62
        en = 1;
        wait_tick();
        measure(hi, lo);
        chk("p125_high", 32'(hi), 63);
        chk("p125_low", 32'(lo), 62);

        // load during HIGH: pending changes now, running period at next tick
        cyc(); cyc();
        bus.load = 1; bus.load_val = 10;
        cyc();
        bus.load = 0;
        chk("load_pending", 32'(bus.period_next), 10);
        chk("load_period_held", 32'(period), 125);
        wait_tick();
        chk("load_period_applied", 32'(period), 10);
        measure(hi, lo);
        chk("p10_high", 32'(hi), 5);
        chk("p10_low", 32'(lo), 5);

        // en dropped 3 cycles into HIGH: period completes, then idle low
        cyc(); cyc();
        en = 0;
        hc = 3; tk = 0;
        repeat (30) begin
            cyc();
            hc += int'(clk_out);
            tk += int'(tick);
        end
        chk("stop_high_total", 32'(hc), 5);
        chk("stop_no_tick", 32'(tk), 0);
        chk("stop_clk_low", 32'(clk_out), 0);

        // async reset mid-LOW
        en = 1;
        wait_tick();
        repeat (6) cyc();
        chk("pre_rst_in_low", 32'(clk_out), 0);
        #2 rst_r = 1;
        #1;
        chk("arst_clk_out", 32'(clk_out), 0);
        chk("arst_period", 32'(period), 125);
        chk("arst_period_next", 32'(bus.period_next), 125);
        model_reset();
        @(negedge clk50);
        rst_r = 0;
        cyc();
        chk("restart_tick", 32'(tick), 1);
        chk("restart_period", 32'(period), 125);

        // randomized traffic against the model
        for (int n = 0; n < 3000; n++) begin
            if (n % 200 == 0) begin
                bus.min_p = 8'($urandom_range(0, 120));
                bus.max_p = 8'($urandom_range(60, 255));
            end
            en            = ($urandom % 16) != 0;
            bus.load      = ($urandom % 20) == 0;
            bus.load_val  = 8'($urandom);
            bus.cmd_valid = ($urandom % 4) == 0;
            bus.inc_dec   = 2'($urandom);
            bus.step      = 8'($urandom_range(0, 40));
            cyc();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached, total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/tunable_clock_gen.md
TUNABLE_CLOCK_GEN -- requirements
Module: tunable_clock_gen

Interface
REQ-001 SHALL have parameter W, default 8: width of all period/step/limit values.
REQ-002 SHALL have parameter INIT_PERIOD, default 125: period in clk50 cycles after reset.
REQ-003 SHALL have parameter MIN_LEGAL, default 2: absolute lower bound on any period.
REQ-004 SHALL have port clk50, input, 1: sole clock.
REQ-005 SHALL have port rst_r, input, 1: reset, asynchronous, active-high.
REQ-006 SHALL have port en, input, 1: 1 runs the generator; 0 stops it.
REQ-007 SHALL have port load, input, 1: 1 replaces the pending period with load_val.
REQ-008 SHALL have port load_val, input, W: period value to load.
REQ-009 SHALL have port cmd_valid, input, 1: qualifies inc_dec for one cycle.
REQ-010 SHALL have port inc_dec, input, 2: 01 lengthens the period, 10 shortens it, 00/11 hold.
REQ-011 SHALL have port step, input, W: adjustment amount per command.
REQ-012 SHALL have port min_p, input, W: runtime lower limit.
REQ-013 SHALL have port max_p, input, W: runtime upper limit.
REQ-014 SHALL have port clk_out, output, 1: generated clock, registered.
REQ-015 SHALL have port period, output, W: period currently in use.
REQ-016 SHALL have port period_next, output, W: pending period.
REQ-017 SHALL have port tick, output, 1: one-cycle pulse on each clk_out rising edge.
REQ-018 SHALL have ports at_min and at_max, output, 1 each: pending period equals the effective limit.

Function
REQ-019 SHALL implement FSM states IDLE, HIGH and LOW.
REQ-020 IDLE: clk_out=0; en=1 -> HIGH next cycle, with clk_out=1, tick=1, period<=period_next and the phase counter loaded.
REQ-021 SHALL keep HIGH for P-floor(P/2) cycles, then LOW for floor(P/2) cycles, where P=period.
REQ-022 At the end of LOW, en=1 -> HIGH (tick=1, period<=period_next); en=0 -> IDLE.
REQ-023 en falling mid-period SHALL NOT truncate the period; the current period completes first (glitch-free stop).
REQ-024 period SHALL change only on HIGH entry, so no clk_out phase is shortened by a command.
REQ-025 Pending update priority: load over cmd_valid; a new value is visible on period_next the cycle after the request.
REQ-026 Lengthen command: period_next <= min(period_next+step, max_eff), computed at W+1 bits with no wrap.
REQ-027 Shorten command: period_next <= max(period_next-step, min_eff), computed signed with no underflow.
REQ-028 min_eff = max(min_p, MIN_LEGAL); max_eff = max_p.
REQ-029 If min_eff > max_eff, min_eff SHALL win: clamp to max_eff first, then to min_eff.
REQ-030 load SHALL apply the same clamp to load_val.
REQ-031 at_min = (period_next==min_eff); at_max = (period_next==max_eff); both combinational from registers and limits.
REQ-032 Commands SHALL be accepted in every state, including IDLE; multiple commands within one clk_out period accumulate, and only the final value is used.
REQ-033 step=0 or inc_dec in {00,11} SHALL leave period_next unchanged.

Reset
REQ-034 While rst_r=1, asynchronously: state=IDLE, clk_out=0, tick=0, period=period_next=INIT_PERIOD (clamped to MIN_LEGAL), phase counter=0.
REQ-035 Reset mid-period SHALL drive clk_out low immediately; after release, restart requires en=1 and follows REQ-020.

Structure
REQ-036 A shared package SHALL hold the FSM state typedef and the inc_dec encodings (CMD_HOLD, CMD_INC, CMD_DEC).
REQ-037 SHALL contain one sub-module, period_clamp: combinational saturating add/subtract plus clamp, reused for both command and load paths.

Verification
REQ-038 Reset, en=1, no commands -> clk_out period 125 cycles (high 63, low 62); tick every 125 cycles.
REQ-039 load=1, load_val=10 during HIGH -> period_next=10 next cycle; period stays 125 until the next tick, then high 5 / low 5.
REQ-040 min_p=90, max_p=160, period_next=155, step=20, INC -> 160 and at_max=1; a second INC stays at 160.
REQ-041 min_p=0, period_next=5, step=50, DEC -> period_next=2 (MIN_LEGAL) and at_min=1; no wrap to 211.
REQ-042 min_p=100, max_p=80, load_val=90 -> period_next=100.
REQ-043 en dropped 3 cycles into HIGH -> the full period completes and clk_out ends low in IDLE; rst_r pulse mid-LOW -> clk_out=0 and period=125 immediately.
